// File: rtl/neuron_mac_sequencer.sv
// Shared-MAC sequencer for one neuron: issues operand indices, accumulates delayed products, adds bias, applies ReLU.
// Optional build macro NEURON_SEQ_SAT_EN: saturate the post-ReLU result to 32'h7FFF_FFFF instead of wrapping.
module neuron_mac_sequencer #(
    parameter int MAX_LEN   = 824,
    parameter int IDX_W     = 16,
    parameter int MULT_LAT  = 1,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [IDX_W-1:0] len,
    input  logic [15:0]      bias,
    output logic [IDX_W-1:0] idx,
    input  logic [31:0]      prod,
    output logic             busy,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] MAX_LEN_W = IDX_W'(MAX_LEN);
    localparam logic signed [ACC_W-1:0] POS_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};

    state_t state, state_nxt;

    logic        [IDX_W-1:0]  last_idx;
    logic signed [15:0]       bias_q;
    logic signed [ACC_W-1:0]  acc;
    logic        [MULT_LAT-1:0] vld_p;
    logic        [MULT_LAT-1:0] vld_nxt;
    logic                     vld_tail;
    logic        [IDX_W-1:0]  len_clamp;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  biased_sum;

    function automatic logic [31:0] relu_sat(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] r;
        r = (s < 0) ? '0 : s;
`ifdef NEURON_SEQ_SAT_EN
        if (r > POS_MAX) begin
            r = POS_MAX;
        end
`endif
        return r[31:0];
    endfunction

    assign len_clamp  = (len > MAX_LEN_W) ? MAX_LEN_W : len;
    assign prod_ext   = {{(ACC_W-32){prod[31]}}, prod};
    assign bias_ext   = {{(ACC_W-16){bias_q[15]}}, bias_q} <<< FRAC_BITS;
    assign biased_sum = acc + bias_ext;

    // The valid pipe tracks in-flight multiplies; its tail lines up with the matching prod.
    assign vld_nxt  = (vld_p << 1) | MULT_LAT'(state == ISSUE);
    assign vld_tail = vld_p[MULT_LAT-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        out_valid = (state == OUT);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? BIAS : ISSUE;
                end
            end
            ISSUE: begin
                if (idx == last_idx) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_nxt == '0) begin
                    state_nxt = BIAS;
                end
            end
            BIAS: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx      <= '0;
            last_idx <= '0;
            bias_q   <= '0;
            acc      <= '0;
            vld_p    <= '0;
            out_data <= '0;
        end else begin
            vld_p <= vld_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        idx    <= '0;
                        bias_q <= bias;
                        if (len != '0) begin
                            last_idx <= len_clamp - 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (idx != last_idx) begin
                        idx <= idx + 1'b1;
                    end
                    if (vld_tail) begin
                        acc <= acc + prod_ext;
                    end
                end
                DRAIN: begin
                    if (vld_tail) begin
                        acc <= acc + prod_ext;
                    end
                end
                BIAS: begin
                    out_data <= relu_sat(biased_sum);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
